// File: rtl/raid_pkg.sv
// Shared codes for the RAID array controller: raid modes, completion status
// values and the controller state enumeration.
package raid_pkg;

    typedef enum logic [3:0] {
        MODE_RAID1 = 4'd0,
        MODE_RAID0 = 4'd1,
        MODE_RAID5 = 4'd5
    } raid_mode_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_CORR    = 2'd1,
        ST_UNCORR  = 2'd2,
        ST_TIMEOUT = 2'd3
    } raid_status_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RESP
    } raid_state_e;

endpackage

// File: rtl/raid_lane_map.sv
// Combinational lane mapping: host lanes <-> drive lanes for each raid mode,
// including RAID5 parity generation, reconstruction and consistency check.
module raid_lane_map
    import raid_pkg::*;
#(
    parameter int NDRIVES = 4,
    parameter int LANE_W  = 8,
    parameter int ADDR_W  = 32
) (
    input  logic [3:0]                mode,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [NDRIVES*LANE_W-1:0] wdata,
    input  logic [NDRIVES-1:0]        fail_mask,
    input  logic [NDRIVES*LANE_W-1:0] rdata,
    output logic                      abort,
    output logic [NDRIVES*LANE_W-1:0] wr_lanes,
    output logic [NDRIVES*LANE_W-1:0] rd_lanes,
    output logic [1:0]                status
);
    localparam int IDX_W = $clog2(NDRIVES);
    localparam int CNT_W = IDX_W + 1;

    logic [NDRIVES-1:0][LANE_W-1:0] w, r, wl, rl;
    logic [IDX_W-1:0]               par_idx;
    logic [IDX_W-1:0]               j;
    logic [CNT_W-1:0]               nfail;
    logic [LANE_W-1:0]              parity, syndrome, first;
    logic                           found, mismatch;

    assign w        = wdata;
    assign r        = rdata;
    assign wr_lanes = wl;
    assign rd_lanes = rl;
    assign par_idx  = IDX_W'(addr % ADDR_W'(NDRIVES));

    // With one drive missing, the XOR of the healthy lanes is the missing lane;
    // with none missing it must be zero for a consistent stripe.
    always_comb begin
        nfail    = '0;
        syndrome = '0;
        first    = '0;
        found    = 1'b0;
        mismatch = 1'b0;
        parity   = '0;
        for (int d = 0; d < NDRIVES; d++) begin
            if (fail_mask[d]) begin
                nfail = nfail + CNT_W'(1);
            end else begin
                syndrome = syndrome ^ r[d];
                if (!found) begin
                    first = r[d];
                    found = 1'b1;
                end
            end
        end
        for (int d = 0; d < NDRIVES; d++)
            if (!fail_mask[d] && r[d] != first) mismatch = 1'b1;
        for (int k = 0; k < NDRIVES-1; k++)
            parity = parity ^ w[k];
    end

    always_comb begin
        wl     = '0;
        rl     = '0;
        abort  = 1'b0;
        status = ST_OK;
        j      = '0;
        case (mode)
            MODE_RAID0: begin
                abort = (nfail != '0);
                wl    = w;
                rl    = r;
            end
            MODE_RAID1: begin
                abort = (nfail == CNT_W'(NDRIVES));
                for (int d = 0; d < NDRIVES; d++) wl[d] = w[0];
                rl[0] = first;
                if (!write && mismatch)  status = ST_UNCORR;
                else if (nfail != '0)    status = ST_CORR;
            end
            MODE_RAID5: begin
                abort = (nfail > CNT_W'(1));
                for (int d = 0; d < NDRIVES; d++) begin
                    if (IDX_W'(d) == par_idx) begin
                        wl[d] = parity;
                    end else begin
                        wl[d] = w[j];
                        rl[j] = fail_mask[d] ? syndrome : r[d];
                        j     = j + IDX_W'(1);
                    end
                end
                if (nfail != '0)                      status = ST_CORR;
                else if (!write && syndrome != '0)    status = ST_UNCORR;
            end
            default: begin
                abort  = 1'b1;
                status = ST_UNCORR;
            end
        endcase
    end

endmodule

// File: rtl/raid_array_ctrl.sv
// RAID array controller: accepts one host stripe request, strobes the member
// drives, waits for their busy handshake with a timeout and reports a status.
module raid_array_ctrl
    import raid_pkg::*;
#(
    parameter int NDRIVES = 4,
    parameter int LANE_W  = 8,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [3:0]                req_mode,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [NDRIVES*LANE_W-1:0] req_wdata,
    input  logic [NDRIVES-1:0]        fail_mask,
    output logic                      resp_valid,
    output logic [NDRIVES*LANE_W-1:0] resp_rdata,
    output logic [1:0]                resp_status,
    output logic [ADDR_W-1:0]         drv_addr,
    output logic [NDRIVES-1:0]        drv_rd,
    output logic [NDRIVES-1:0]        drv_wr,
    output logic [NDRIVES*LANE_W-1:0] drv_wdata,
    input  logic [NDRIVES*LANE_W-1:0] drv_rdata,
    input  logic [NDRIVES-1:0]        drv_busy
);
    localparam int DW    = NDRIVES*LANE_W;
    localparam int CNT_W = $clog2(TIMEOUT+1);

    raid_state_e         state, state_n;
    logic [3:0]          mode_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DW-1:0]       wdata_q;
    logic [NDRIVES-1:0]  fail_q;
    logic [CNT_W-1:0]    cnt;
    logic                rdy_q;
    logic                abort;
    logic [DW-1:0]       wr_lanes, rd_lanes;
    logic [1:0]          map_status;
    logic                accept, in_wait, tgt_busy, timeout_hit, active;
    logic                resp_load;
    logic [1:0]          status_n;
    logic [DW-1:0]       rdata_n;

    assign accept      = req_valid && rdy_q;
    assign req_ready   = rdy_q;
    assign in_wait     = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign active      = (state == ISSUE) || in_wait;
    assign tgt_busy    = |(drv_busy & ~fail_q);
    // WAIT entry sees cnt=0, so the TIMEOUT-th waiting cycle has cnt=TIMEOUT-1.
    assign timeout_hit = in_wait && (cnt == CNT_W'(TIMEOUT-1));

    raid_lane_map #(
        .NDRIVES(NDRIVES),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) u_map (
        .mode     (mode_q),
        .write    (write_q),
        .addr     (addr_q),
        .wdata    (wdata_q),
        .fail_mask(fail_q),
        .rdata    (drv_rdata),
        .abort    (abort),
        .wr_lanes (wr_lanes),
        .rd_lanes (rd_lanes),
        .status   (map_status)
    );

    // Ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rdy_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n == IDLE);
            cnt   <= in_wait ? cnt + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fail_q  <= '0;
        end else if (accept) begin
            mode_q  <= req_mode;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fail_q  <= fail_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata  <= '0;
            resp_status <= '0;
        end else if (resp_load) begin
            resp_rdata  <= rdata_n;
            resp_status <= status_n;
        end
    end

    always_comb begin
        state_n   = state;
        resp_load = 1'b0;
        status_n  = ST_OK;
        rdata_n   = '0;
        case (state)
            IDLE: if (accept) state_n = ISSUE;
            ISSUE: begin
                if (abort) begin
                    state_n   = RESP;
                    resp_load = 1'b1;
                    status_n  = ST_UNCORR;
                end else begin
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (timeout_hit) begin
                    state_n   = RESP;
                    resp_load = 1'b1;
                    status_n  = ST_TIMEOUT;
                end else if (tgt_busy) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout_hit) begin
                    state_n   = RESP;
                    resp_load = 1'b1;
                    status_n  = ST_TIMEOUT;
                end else if (!tgt_busy) begin
                    state_n   = RESP;
                    resp_load = 1'b1;
                    status_n  = map_status;
                    rdata_n   = write_q ? '0 : rd_lanes;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign drv_rd     = (state == ISSUE && !abort && !write_q) ? ~fail_q : '0;
    assign drv_wr     = (state == ISSUE && !abort &&  write_q) ? ~fail_q : '0;
    assign drv_addr   = active ? addr_q : '0;
    assign drv_wdata  = (active && write_q && !abort) ? wr_lanes : '0;

endmodule
